// File: rtl/serv_wakeup.sv
// WFI sleep controller: gates the core clock enable after a WFI instruction retires
// and restores it a fixed number of cycles after an enabled interrupt becomes pending.
module serv_wakeup #(
  parameter int WAKE_DELAY = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wfi,
  input  logic       i_cnt_done,
  input  logic       i_timer_irq,
  input  logic       i_external_irq,
  input  logic       i_mtie,
  input  logic       i_meie,
  output logic       o_clk_en,
  output logic       o_sleeping,
  output logic       o_wake,
  output logic [1:0] o_wake_cause
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SLEEP,
    ST_WAKE
  } state_t;

  localparam logic [3:0] LP_DELAY = 4'(WAKE_DELAY);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [1:0] w_cause;
  logic       w_irq_en;
  logic       w_wake;
  logic       w_run;
  logic       r_clk_en;
  logic       r_sleeping;
  logic       r_wake;
  logic [1:0] r_wake_cause;

  assign w_cause  = {i_external_irq & i_meie, i_timer_irq & i_mtie};
  assign w_irq_en = |w_cause;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      ST_IDLE:  if (i_wfi) w_next = ST_ARMED;
      ST_ARMED: if (i_cnt_done) w_next = w_irq_en ? ST_IDLE : ST_SLEEP;
      ST_SLEEP: begin
        if (w_irq_en) begin
          if (LP_DELAY == 4'd0) begin
            w_next = ST_IDLE;
          end else begin
            w_next     = ST_WAKE;
            w_cnt_next = LP_DELAY;
          end
        end
      end
      ST_WAKE: begin
        w_cnt_next = r_cnt - 4'd1;
        // <= 1 rather than == 1 so a corrupted zero count can never strand the core asleep
        if (r_cnt <= 4'd1) w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change only on the edge.
  assign w_run  = (w_next == ST_IDLE) || (w_next == ST_ARMED);
  assign w_wake = (w_next == ST_IDLE) && ((r_state == ST_SLEEP) || (r_state == ST_WAKE));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_clk_en     <= 1'b1;
      r_sleeping   <= 1'b0;
      r_wake       <= 1'b0;
      r_wake_cause <= 2'b00;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_clk_en   <= w_run;
      r_sleeping <= ~w_run;
      r_wake     <= w_wake;
      if ((r_state == ST_SLEEP) && w_irq_en) r_wake_cause <= w_cause;
    end
  end

  assign o_clk_en     = r_clk_en;
  assign o_sleeping   = r_sleeping;
  assign o_wake       = r_wake;
  assign o_wake_cause = r_wake_cause;

endmodule
